ifu_fetch: RTL and testbench

- Instruction fetch controller directly upstream of the core's instruction RAM.
- Generates the next fetch address and read enable, and captures each returned instruction/PC pair one cycle after the read.
- Buffers fetched pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles the post-reset boot read, jump/branch redirects with wrong-path kill, and a halt request.

---
 rtl/ifu_fetch.sv | 144 ++++++++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch controller: drives the instruction RAM, buffers the returned PC/instruction pairs and hands them to decode.
// Define IFU_BYPASS_EN to let a response go straight to decode when the buffer is empty.
module ifu_fetch #(
  parameter logic [31:0] RST_PC     = 32'h0800_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_n_o,
  output logic        iram_rd_o,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        iram_rstn_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        halt_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   buf_inst [FIFO_DEPTH];
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fpc;
  logic          inflight;
  logic          kill;
  logic [31:0]   hold_inst;
  logic [31:0]   hold_pc;

  logic          resp;
  logic          resp_ok;
  logic          empty;
  logic          deq;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic          credit_ok;
  logic          can_issue;
  logic          issue;
  logic [31:0]   target;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^jump_addr_i[1:0];

  always_comb begin
    // A response lands only once the boot read has completed; the jump cycle drops whatever lands.
    resp      = inflight & ~iram_rstn_i;
    resp_ok   = resp & ~kill & ~jump_i;
    empty     = (count == '0);
    target    = {jump_addr_i[31:2], 2'b00};
`ifdef IFU_BYPASS_EN
    inst_valid_o = ~empty | resp_ok;
    if (!empty) begin
      inst_o    = buf_inst[rd_ptr];
      inst_pc_o = buf_pc[rd_ptr];
    end else if (resp_ok) begin
      inst_o    = inst_i;
      inst_pc_o = pc_i;
    end else begin
      inst_o    = hold_inst;
      inst_pc_o = hold_pc;
    end
`else
    inst_valid_o = ~empty;
    inst_o       = empty ? hold_inst : buf_inst[rd_ptr];
    inst_pc_o    = empty ? hold_pc   : buf_pc[rd_ptr];
`endif
    deq       = inst_valid_o & inst_ready_i;
    pop       = deq & ~empty;
    push      = resp_ok & ~(empty & deq);
    occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
    credit_ok = (occ < (CW+1)'(FIFO_DEPTH));
    can_issue = ~halt_i & ~iram_rstn_i;
    issue     = can_issue & (jump_i | credit_ok);
    iram_rd_o = issue;
    pc_n_o    = jump_i ? target : fpc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc       <= RST_PC + 32'd4;
      inflight  <= 1'b1;
      kill      <= 1'b0;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      hold_inst <= inst_o;
      hold_pc   <= inst_pc_o;
      // The boot read stays outstanding while the RAM is still performing it.
      inflight  <= issue | (inflight & iram_rstn_i);
      if (jump_i) begin
        fpc  <= issue ? target + 32'd4 : target;
        kill <= inflight & iram_rstn_i;
      end else begin
        if (issue) begin
          fpc <= fpc + 32'd4;
        end
        if (resp) begin
          kill <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (jump_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= inst_i;
        buf_pc[wr_ptr]   <= pc_i;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CW'(FIFO_DEPTH)))
    else $error("push into a full instruction buffer");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: behavioural instruction RAM, in-order PC scoreboard and directed timing checks.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h0800_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_n;
  logic        iram_rd;
  logic [31:0] ram_pc;
  logic [31:0] ram_inst;
  logic        boot;
  logic        jump;
  logic [31:0] jump_addr;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int          checks;
  int          errors;
  int          delivered;
  logic [31:0] exp_q[$];

  ifu_fetch #(.RST_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_n_o       (pc_n),
    .iram_rd_o    (iram_rd),
    .pc_i         (ram_pc),
    .inst_i       (ram_inst),
    .iram_rstn_i  (boot),
    .jump_i       (jump),
    .jump_addr_i  (jump_addr),
    .halt_i       (halt),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // RAM: reads RST_PC by itself in the first cycle after reset, else on iram_rd.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot     <= 1'b1;
      ram_pc   <= '0;
      ram_inst <= '0;
    end else begin
      boot <= 1'b0;
      if (boot) begin
        ram_pc   <= RST_PC;
        ram_inst <= rom(RST_PC);
      end else if (iram_rd) begin
        ram_pc   <= pc_n;
        ram_inst <= rom(pc_n);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_stream(input logic [31:0] base);
    logic [31:0] a;
    a = base;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted instruction must be the next expected PC of the current stream.
  always @(negedge clk) begin
    if (rst_n && iram_rd) begin
      check("pc_n_align", {30'b0, pc_n[1:0]}, 32'h0);
    end
    if (rst_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pc %h expected no delivery", inst_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", inst_pc, e);
        check("sb_inst", inst, rom(e));
        delivered++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    checks     = 0;
    errors     = 0;
    delivered  = 0;
    rst_n      = 1'b0;
    inst_ready = 1'b1;
    halt       = 1'b0;
    jump       = 1'b0;
    jump_addr  = '0;
    load_stream(RST_PC);
    tick();
    tick();
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_rd", {31'b0, iram_rd}, 32'h0);
    check("rst_pc_n", pc_n, RST_PC + 32'd4);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Boot: read forced off in the boot cycle, first delivery two edges later, then no gaps.
    rst_n = 1'b1;
    #1;
    check("boot_rd_forced", {31'b0, iram_rd}, 32'h0);
    tick();
    check("boot_c1_valid", {31'b0, inst_valid}, 32'h0);
    check("boot_c1_rd", {31'b0, iram_rd}, 32'h1);
    check("boot_c1_pc_n", pc_n, RST_PC + 32'd4);
    tick();
    check("boot_c2_valid", {31'b0, inst_valid}, 32'h1);
    check("boot_c2_pc", inst_pc, RST_PC);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stream_no_gap", {31'b0, inst_valid}, 32'h1);
    end

    // Decode stall: buffer fills, no reads while credit is exhausted.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_rd", {31'b0, iram_rd}, 32'h0);
      check("stall_valid", {31'b0, inst_valid}, 32'h1);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    check("stall_release_rd", {31'b0, iram_rd}, 32'h1);
    repeat (3) tick();

    // Redirect with one buffered entry and one read outstanding.
    jump      = 1'b1;
    jump_addr = 32'h0000_0103;
    #1;
    check("jump_pc_n", pc_n, 32'h0000_0100);
    check("jump_rd", {31'b0, iram_rd}, 32'h1);
    tick();
    jump = 1'b0;
    load_stream(32'h0000_0100);
    #1;
    check("jump_flush", {31'b0, inst_valid}, 32'h0);
    tick();
    check("jump_first_valid", {31'b0, inst_valid}, 32'h1);
    check("jump_first_pc", inst_pc, 32'h0000_0100);
    repeat (3) tick();

    // Halt: outstanding response still delivered, buffer drains, no new reads.
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_rd", {31'b0, iram_rd}, 32'h0);
      if (i == 3) check("halt_drained", {31'b0, inst_valid}, 32'h0);
      tick();
    end
    halt = 1'b0;
    #1;
    check("halt_resume_rd", {31'b0, iram_rd}, 32'h1);
    repeat (4) tick();

    // Back-to-back redirects: only the second target stream is delivered.
    jump      = 1'b1;
    jump_addr = 32'h0000_0040;
    #1;
    check("jump1_pc_n", pc_n, 32'h0000_0040);
    tick();
    jump_addr = 32'h0000_0080;
    load_stream(32'h0000_0080);
    #1;
    check("jump2_pc_n", pc_n, 32'h0000_0080);
    check("jump2_rd", {31'b0, iram_rd}, 32'h1);
    tick();
    jump = 1'b0;
    repeat (6) tick();

    // Fill the buffer, then reset asynchronously mid-cycle.
    inst_ready = 1'b0;
    repeat (4) tick();
    #1;
    check("full_valid", {31'b0, inst_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, inst_valid}, 32'h0);
    check("async_rst_pc", inst_pc, 32'h0);
    check("async_rst_pc_n", pc_n, RST_PC + 32'd4);
    check("async_rst_rd", {31'b0, iram_rd}, 32'h0);
    load_stream(RST_PC);
    inst_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    d0 = delivered;
    tick();
    tick();
    check("reboot_valid", {31'b0, inst_valid}, 32'h1);
    check("reboot_pc", inst_pc, RST_PC);
    repeat (6) tick();
    check("reboot_count", 32'(delivered - d0), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
